// File: rtl/systolic_is_pkg.sv
// Shared types and helpers for the input-stationary systolic array.
// Holds the sequencer state encoding, accumulator sizing and the PE multiply.
package systolic_is_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DRAIN
    } state_t;

    // Product width plus enough headroom for ROWS additions.
    function automatic int acc_width(input int d_w, input int rows);
        return 2 * d_w + $clog2(rows);
    endfunction

    // Multiply two d_w-bit operands (d_w <= 32) after sign or zero extension.
    // The 64-bit result is already extended; callers truncate to ACC_W.
    function automatic logic [63:0] ext_mul(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          d_w,
        input bit          signed_mode
    );
        logic [31:0]        sh;
        logic [31:0]        ta;
        logic [31:0]        tb;
        logic signed [63:0] xa;
        logic signed [63:0] xb;
        sh = 32'(32 - d_w);
        ta = a << sh;
        tb = b << sh;
        if (signed_mode) begin
            xa = 64'(signed'(ta) >>> sh);
            xb = 64'(signed'(tb) >>> sh);
        end else begin
            xa = {32'd0, ta >> sh};
            xb = {32'd0, tb >> sh};
        end
        return xa * xb;
    endfunction

endpackage

// File: rtl/systolic_is_seq_if.sv
// Handshake bundle for systolic_is_seq: weight rows, activations, results.
// master = producer/consumer side, slave = the array.
interface systolic_is_seq_if
    import systolic_is_pkg::*;
#(
    parameter int D_W   = 8,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int ACC_W = acc_width(D_W, ROWS)
);
    logic                  w_valid;
    logic                  w_ready;
    logic [COLS*D_W-1:0]   w_data;
    logic                  a_valid;
    logic                  a_ready;
    logic [ROWS*D_W-1:0]   a_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [COLS*ACC_W-1:0] out_data;
    logic                  busy;
    logic                  weights_loaded;

    modport master (
        output w_valid, w_data, a_valid, a_data, out_ready,
        input  w_ready, a_ready, out_valid, out_data,
        input  busy, weights_loaded
    );

    modport slave (
        input  w_valid, w_data, a_valid, a_data, out_ready,
        output w_ready, a_ready, out_valid, out_data,
        output busy, weights_loaded
    );
endinterface

// File: rtl/systolic_is_seq_skew_line.sv
// Enabled register chain used for input skew and output de-skew.
// Ports: clk, rst (async, active-low), en, d -> q delayed DEPTH cycles.
module skew_line #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    if (DEPTH == 0) begin : g_wire
        logic unused_ok;
        assign unused_ok = ^{clk, rst, en};
        assign q = d;
    end else begin : g_reg
        logic [W-1:0] r_q [DEPTH];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
            end else if (en) begin
                r_q[0] <= d;
                for (int i = 1; i < DEPTH; i++) r_q[i] <= r_q[i-1];
            end
        end
        assign q = r_q[DEPTH-1];
    end
endmodule

// File: rtl/systolic_is_seq.sv
// Input-stationary ROWS x COLS systolic array with load/compute sequencer.
// Ports: clk, rst (async, active-low), bus (systolic_is_seq_if.slave).
module systolic_is_seq
    import systolic_is_pkg::*;
#(
    parameter int D_W    = 8,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int ACC_W  = acc_width(D_W, ROWS),
    parameter int SIGNED = 1
) (
    input logic              clk,
    input logic              rst,
    systolic_is_seq_if.slave bus
);
    localparam int L     = ROWS + COLS - 1;
    localparam int CNT_W = $clog2(ROWS + 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wl_q, wl_d;
    logic                  live_q;
    logic [L-1:0]          vld_q;
    logic                  out_valid_q;
    logic [COLS*ACC_W-1:0] out_data_q;
    logic [COLS*ACC_W-1:0] dsk;
    logic [ROWS*D_W-1:0]   a_in;
    logic                  stall, en;
    logic                  w_rdy, a_rdy;
    logic                  w_fire, a_fire;

    // A stalled result freezes the whole datapath, not just the output.
    assign stall  = out_valid_q && !bus.out_ready;
    assign en     = !stall;
    assign w_fire = bus.w_valid && w_rdy;
    assign a_fire = bus.a_valid && a_rdy;
    assign a_in   = a_fire ? bus.a_data : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wl_q    <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wl_q    <= wl_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wl_d    = wl_q;
        w_rdy   = 1'b0;
        a_rdy   = 1'b0;
        unique case (state_q)
            IDLE, LOAD: begin
                w_rdy = live_q;
                if (bus.w_valid && live_q) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = LOAD;
                    if (cnt_q == CNT_W'(ROWS - 1)) begin
                        cnt_d   = '0;
                        wl_d    = 1'b1;
                        state_d = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                // A pending weight beat takes priority over activations.
                a_rdy = !stall && !bus.w_valid;
                if (bus.w_valid) begin
                    wl_d    = 1'b0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (vld_q == '0 && !out_valid_q) begin
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (en) begin
            vld_q       <= L'({vld_q, a_fire});
            out_valid_q <= vld_q[L-1];
            if (vld_q[L-1]) out_data_q <= dsk;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [D_W-1:0] a_sk;
        logic           unused_act;

        skew_line #(.W(D_W), .DEPTH(r)) u_skew (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (a_in[r*D_W +: D_W]),
            .q   (a_sk)
        );

        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [D_W-1:0]   w_q, w_in;
            logic [D_W-1:0]   act_q, act_in;
            logic [ACC_W-1:0] sum_q, sum_in, prod;

            // Weight rows shift downward; new beats always enter row 0.
            if (r == 0) begin : g_top
                assign w_in   = bus.w_data[c*D_W +: D_W];
                assign sum_in = '0;
            end else begin : g_mid
                assign w_in   = g_row[r-1].g_col[c].w_q;
                assign sum_in = g_row[r-1].g_col[c].sum_q;
            end

            if (c == 0) begin : g_lft
                assign act_in = a_sk;
            end else begin : g_inr
                assign act_in = g_col[c-1].act_q;
            end

            assign prod = ACC_W'(ext_mul(32'(act_in), 32'(w_q),
                                         D_W, SIGNED != 0));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) w_q <= '0;
                else if (w_fire) w_q <= w_in;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    act_q <= '0;
                    sum_q <= '0;
                end else if (en) begin
                    act_q <= act_in;
                    sum_q <= sum_in + prod;
                end
            end
        end

        assign unused_act = ^g_col[COLS-1].act_q;
    end

    // Column c finishes c cycles after column 0; re-align the columns.
    for (genvar c = 0; c < COLS; c++) begin : g_dsk
        logic [ACC_W-1:0] q;
        skew_line #(.W(ACC_W), .DEPTH(COLS - 1 - c)) u_dsk (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (g_row[ROWS-1].g_col[c].sum_q),
            .q   (q)
        );
        assign dsk[c*ACC_W +: ACC_W] = q;
    end

    assign bus.w_ready        = w_rdy;
    assign bus.a_ready        = a_rdy;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_data       = out_data_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.weights_loaded = wl_q;
endmodule
